// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable data width and parity, feeding a first-word-fall-through
// receive FIFO, with sticky frame, parity and overrun error flags.
module uart_rx_fifo #(
  parameter int CLK_DIVIDER = 4166,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  output logic [7:0]                    read_data,
  output logic                          read_valid,
  input  logic                          read_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clear
);

  localparam int CW = $clog2(CLK_DIVIDER);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIVIDER - 1);
  localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD      = 1'(PARITY == 1);
  localparam bit            HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAITHI
  } rx_state_t;

  rx_state_t      state_q, state_d;
  logic [1:0]     sync_q;
  logic           rxs;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_ok_q, par_ok_d;
  logic           push, set_frame, set_par;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic           pop, full, accept, drop;
  logic           frame_err_q, parity_err_q, overrun_q;

  assign rxs = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == FULL_M1) ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    push      = 1'b0;
    set_frame = 1'b0;
    set_par   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            idx_d    = '0;
            shift_d  = '0;
            par_ok_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q[2:0]] = rxs;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = HAS_PAR ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        // Upper bits of shift_q are zero, so the full reduction equals the data parity.
        if (cnt_q == FULL_M1) begin
          par_ok_d = (((^shift_q) ^ rxs) == ODD);
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          if (rxs) begin
            state_d = S_IDLE;
            if (par_ok_q) push = 1'b1;
            else          set_par = 1'b1;
          end else begin
            state_d   = S_WAITHI;
            set_frame = 1'b1;
          end
        end
      end
      S_WAITHI: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake: read_valid means read_data holds the head entry; read_ack with read_valid
  // high pops it on that clock edge, read_ack with read_valid low has no effect.
  assign pop     = read_ack && (count_q != '0);
  assign full    = (count_q == FULL_CNT);
  assign accept  = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign count_d = count_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], serial_in};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      count_q      <= count_d;
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      frame_err_q  <= set_frame | (frame_err_q & ~err_clear);
      parity_err_q <= set_par | (parity_err_q & ~err_clear);
      overrun_q    <= drop | (overrun_q & ~err_clear);
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= shift_q;
  end

  assign read_valid = (count_q != '0);
  assign read_data  = read_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 depth-4 instance and a 7E1 depth-8 instance, each checked
// against a frame-level queue model of accepted bytes and sticky flags.
module tb_uart_rx_fifo;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] line = 2'b11;
  logic [1:0] ack = 2'b00;
  logic [1:0] clr = 2'b00;

  wire  [1:0] vld, busy, ferr, perr, ovr;
  wire  [7:0] rd [2];
  wire  [2:0] cnt_a;
  wire  [3:0] cnt_b;
  wire  [4:0] cnt [2];

  assign cnt[0] = {2'b00, cnt_a};
  assign cnt[1] = {1'b0, cnt_b};

  int n_checks = 0;
  int n_errors = 0;

  int depth [2] = '{4, 8};
  int dbits [2] = '{8, 7};
  int pmode [2] = '{0, 2};

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit m_ferr [2];
  bit m_perr [2];
  bit m_ovr  [2];

  uart_rx_fifo #(.CLK_DIVIDER(D), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .serial_in(line[0]), .read_data(rd[0]), .read_valid(vld[0]),
    .read_ack(ack[0]), .fifo_count(cnt_a), .rx_busy(busy[0]), .frame_err(ferr[0]),
    .parity_err(perr[0]), .overrun(ovr[0]), .err_clear(clr[0]));

  uart_rx_fifo #(.CLK_DIVIDER(D), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .reset(reset), .serial_in(line[1]), .read_data(rd[1]), .read_valid(vld[1]),
    .read_ack(ack[1]), .fifo_count(cnt_b), .rx_busy(busy[1]), .frame_err(ferr[1]),
    .parity_err(perr[1]), .overrun(ovr[1]), .err_clear(clr[1]));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reference model
  function automatic int model_size(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] model_front(input int s);
    if (model_size(s) == 0) return 8'h00;
    return (s == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void model_push(input int s, input logic [7:0] b);
    if (s == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endfunction

  function automatic void model_pop(input int s);
    if (s == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endfunction

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int s = 0; s < 2; s++) begin
      m_ferr[s] = 0;
      m_perr[s] = 0;
      m_ovr[s]  = 0;
    end
  endfunction

  // drivers
  task automatic send_frame(input int s, input logic [7:0] data, input bit flip_par,
                            input int ack_cyc, input int rst_cyc);
    logic [11:0] bits;
    logic [7:0]  dm;
    logic        pb;
    int          nb;
    bit          popped;
    bit          good;
    dm = (s == 0) ? data : (data & 8'h7F);
    pb = ((pmode[s] == 1) ? ~^dm : ^dm) ^ flip_par;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < dbits[s]; i++) begin
      bits[nb] = dm[i];
      nb++;
    end
    if (pmode[s] != 0) begin
      bits[nb] = pb;
      nb++;
    end
    bits[nb] = 1'b1;
    nb++;
    popped = 0;
    for (int c = 0; c < nb * D; c++) begin
      if (c == rst_cyc) begin
        reset   = 1'b1;
        line[s] = 1'b1;
        ack[s]  = 1'b0;
        tick(1);
        return;
      end
      line[s] = bits[c / D];
      ack[s]  = (c == ack_cyc);
      if (c == ack_cyc && model_size(s) > 0) popped = 1;
      tick(1);
    end
    ack[s]  = 1'b0;
    line[s] = 1'b1;
    good = (pmode[s] == 0) || ((((^dm) ^ pb) == 1'b1) == (pmode[s] == 1));
    if (popped) model_pop(s);
    if (!good)                           m_perr[s] = 1;
    else if (model_size(s) < depth[s])   model_push(s, dm);
    else                                 m_ovr[s] = 1;
  endtask

  task automatic pulse_ack(input int s);
    ack[s] = 1'b1;
    tick(1);
    ack[s] = 1'b0;
    if (model_size(s) > 0) model_pop(s);
  endtask

  task automatic pulse_clear(input int s);
    clr[s] = 1'b1;
    tick(1);
    clr[s] = 1'b0;
    m_ferr[s] = 0;
    m_perr[s] = 0;
    m_ovr[s]  = 0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    tick(1);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({vld[s], busy[s], ferr[s], perr[s], ovr[s]} !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 00000", s, {vld[s], busy[s], ferr[s], perr[s], ovr[s]});
      end
      n_checks++;
      if (cnt[s] !== 5'd0 || rd[s] !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_data[%0d]: got count %0d data %h expected 0 00", s, cnt[s], rd[s]);
      end
    end
  endtask

  task automatic test_basic_8n1();
    send_frame(0, 8'h41, 0, -1, -1);
    n_checks++;
    if (cnt[0] !== 5'd1 || vld[0] !== 1'b1 || rd[0] !== 8'h41) begin
      n_errors++;
      $display("FAIL basic_rx: got count %0d valid %b data %h expected 1 1 41", cnt[0], vld[0], rd[0]);
    end
    n_checks++;
    if ({ferr[0], perr[0], ovr[0]} !== 3'b000) begin
      n_errors++;
      $display("FAIL basic_flags: got %b expected 000", {ferr[0], perr[0], ovr[0]});
    end
    pulse_ack(0);
    n_checks++;
    if (vld[0] !== 1'b0 || cnt[0] !== 5'd0) begin
      n_errors++;
      $display("FAIL basic_pop: got valid %b count %0d expected 0 0", vld[0], cnt[0]);
    end
  endtask

  task automatic test_parity_7e1();
    send_frame(1, 8'h55, 0, -1, -1);
    n_checks++;
    if (cnt[1] !== 5'd1 || rd[1] !== 8'h55 || perr[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_good: got count %0d data %h perr %b expected 1 55 0", cnt[1], rd[1], perr[1]);
    end
    send_frame(1, 8'h55, 1, -1, -1);
    n_checks++;
    if (perr[1] !== 1'b1 || cnt[1] !== 5'd1) begin
      n_errors++;
      $display("FAIL parity_bad: got perr %b count %0d expected 1 1", perr[1], cnt[1]);
    end
    pulse_clear(1);
    n_checks++;
    if (perr[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL parity_clear: got %b expected 0", perr[1]);
    end
    pulse_ack(1);
  endtask

  task automatic test_break();
    line[0] = 1'b0;
    tick(30 * D);
    m_ferr[0] = 1;
    n_checks++;
    if (ferr[0] !== 1'b1 || busy[0] !== 1'b1 || cnt[0] !== 5'd0) begin
      n_errors++;
      $display("FAIL break_hold: got ferr %b busy %b count %0d expected 1 1 0", ferr[0], busy[0], cnt[0]);
    end
    line[0] = 1'b1;
    tick(4);
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL break_release: got busy %b expected 0", busy[0]);
    end
    send_frame(0, 8'h0D, 0, -1, -1);
    n_checks++;
    if (cnt[0] !== 5'd1 || rd[0] !== 8'h0D || ferr[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL break_next: got count %0d data %h ferr %b expected 1 0d 1", cnt[0], rd[0], ferr[0]);
    end
    pulse_ack(0);
    pulse_clear(0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) send_frame(0, 8'h30 + 8'(i), 0, -1, -1);
    n_checks++;
    if (cnt[0] !== 5'd4 || ovr[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL ovr_full: got count %0d overrun %b expected 4 1", cnt[0], ovr[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (vld[0] !== 1'b1 || rd[0] !== model_front(0)) begin
        n_errors++;
        $display("FAIL ovr_read%0d: got valid %b data %h expected 1 %h", i, vld[0], rd[0], model_front(0));
      end
      pulse_ack(0);
    end
    n_checks++;
    if (vld[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_drained: got valid %b expected 0", vld[0]);
    end
    pulse_clear(0);
    for (int i = 0; i < 4; i++) send_frame(0, 8'h30 + 8'(i), 0, -1, -1);
    send_frame(0, 8'h34, 0, 2 + D / 2 + 9 * D, -1);
    n_checks++;
    if (cnt[0] !== 5'd4 || ovr[0] !== 1'b0 || rd[0] !== 8'h31) begin
      n_errors++;
      $display("FAIL ovr_coincident: got count %0d overrun %b data %h expected 4 0 31", cnt[0], ovr[0], rd[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd[0] !== model_front(0)) begin
        n_errors++;
        $display("FAIL ovr_drain%0d: got %h expected %h", i, rd[0], model_front(0));
      end
      pulse_ack(0);
    end
  endtask

  task automatic test_glitch();
    line[0] = 1'b0;
    tick(3);
    line[0] = 1'b1;
    tick(2 * D);
    pulse_ack(0);
    n_checks++;
    if (busy[0] !== 1'b0 || cnt[0] !== 5'd0 || {ferr[0], perr[0], ovr[0]} !== 3'b000) begin
      n_errors++;
      $display("FAIL glitch: got busy %b count %0d flags %b expected 0 0 000", busy[0], cnt[0], {ferr[0], perr[0], ovr[0]});
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(0, 8'h11, 0, -1, -1);
    send_frame(1, 8'h22, 1, -1, -1);
    send_frame(0, 8'hA5, 0, -1, 4 * D + 5);
    model_reset();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({vld[s], busy[s], ferr[s], perr[s], ovr[s]} !== 5'b0 || cnt[s] !== 5'd0 || rd[s] !== 8'h00) begin
        n_errors++;
        $display("FAIL midreset[%0d]: got flags %b count %0d data %h expected 00000 0 00", s, {vld[s], busy[s], ferr[s], perr[s], ovr[s]}, cnt[s], rd[s]);
      end
    end
    reset = 1'b0;
    tick(2);
    send_frame(0, 8'h7E, 0, -1, -1);
    n_checks++;
    if (cnt[0] !== 5'd1 || rd[0] !== 8'h7E || ferr[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_next: got count %0d data %h ferr %b expected 1 7e 0", cnt[0], rd[0], ferr[0]);
    end
    pulse_ack(0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 127));
      send_frame(1, b, 0, -1, -1);
    end
    n_checks++;
    if (cnt[1] !== 5'd3) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d expected 3", cnt[1]);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd[1] !== model_front(1)) begin
        n_errors++;
        $display("FAIL b2b_data%0d: got %h expected %h", i, rd[1], model_front(1));
      end
      pulse_ack(1);
    end
  endtask

  task automatic test_random();
    int s;
    for (int it = 0; it < 24; it++) begin
      s = $urandom_range(0, 1);
      send_frame(s, 8'($urandom_range(0, 255)), (s == 1) && ($urandom_range(0, 3) == 0), -1, -1);
      n_checks++;
      if (cnt[s] !== 5'(model_size(s)) || vld[s] !== (model_size(s) > 0) || rd[s] !== model_front(s)) begin
        n_errors++;
        $display("FAIL rand_fifo[%0d]: got count %0d valid %b data %h expected %0d %h", it, cnt[s], vld[s], rd[s], model_size(s), model_front(s));
      end
      n_checks++;
      if ({ferr[s], perr[s], ovr[s]} !== {m_ferr[s], m_perr[s], m_ovr[s]}) begin
        n_errors++;
        $display("FAIL rand_flags[%0d]: got %b expected %b", it, {ferr[s], perr[s], ovr[s]}, {m_ferr[s], m_perr[s], m_ovr[s]});
      end
      if ($urandom_range(0, 2) != 0) pulse_ack(s);
    end
  endtask

  // report
  initial begin
    model_reset();
    test_reset();
    test_basic_8n1();
    test_parity_7e1();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
